lc3_pipe_controller: RTL
========================

Name: lc3_pipe_controller

Overview:
- Sequencing controller for the LC-3 fetch/decode/execute/writeback pipeline. It drives the stage enables consumed by the decode stage and its neighbours.
- It handles pipeline fill after reset, control-flow stalls for BR/JMP, multi-cycle data-memory access via mem_state, and ALU/memory bypass selects.
- It sits beside the datapath at top level and observes the fetched word, the decode IR, the execute IR and the PSR.

Parameters:
- CTRL_STALL, 3, cycles fetch is frozen after a BR/JMP is fetched (min 2, max 7).
- FILL_DEPTH, 4, number of stages brought up one per cycle after reset (fixed 4, for documentation).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- IMem_dout  in  16  instruction word being fetched this cycle.
- IR  in  16  instruction in decode.
- IR_Exec  in  16  instruction in execute.
- psr  in  3  NZP flags from writeback.
- complete_data  in  1  data-memory access done (single-cycle pulse acceptable).
- enable_fetch  out  1  fetch stage enable.
- enable_updatePC  out  1  PC register load enable.
- enable_decode  out  1  decode stage enable.
- enable_execute  out  1  execute stage enable.
- enable_writeback  out  1  writeback stage enable.
- br_taken  out  1  PC mux select: target (1) or npc (0).
- mem_state  out  2  0=read, 1=indirect read, 2=write, 3=idle.
- bypass_alu_1  out  1  execute src1 forwarded from ALU result.
- bypass_alu_2  out  1  execute src2 forwarded from ALU result.
- bypass_mem_1  out  1  execute src1 forwarded from memory data.
- bypass_mem_2  out  1  execute src2 forwarded from memory data.

Behaviour:
- Opcodes (bits 15:12):
  - ALU: ADD=1, AND=5, NOT=9.
  - Control: BR=0, JMP=C.
  - Loads: LD=2, LDR=6, LDI=A.
  - Stores: ST=3, STR=7, STI=B.
  - LEA=E is treated as ALU.
- Reset (synchronous, while reset=1):
  - All enables 0, br_taken=0, mem_state=3, all bypasses 0.
  - Fill counter cleared, stall counter cleared, memory FSM to IDLE.
  - Reset asserted mid-stall or mid-memory access aborts it identically.
- Fill:
  - First cycle after reset deasserts: enable_fetch=enable_updatePC=1.
  - +1 cycle: enable_decode=1. +2: enable_execute=1. +3: enable_writeback=1.
  - Each enable, once raised, is governed only by the stalls below.
- Memory FSM: IDLE, RD, IND, WR. mem_state = 3/0/1/2 respectively.
  - Entry: in IDLE, when enable_execute=1 and IR_Exec is a load or store, the next state is:
    - RD for LD/LDR.
    - WR for ST/STR.
    - IND for LDI/STI.
  - IND → RD (LDI) or WR (STI) on complete_data.
  - RD/WR → IDLE on complete_data.
  - Each state holds while complete_data=0; there is no timeout.
  - While not IDLE: enable_fetch, enable_updatePC, enable_decode and enable_execute are 0.
  - enable_writeback=1 only in the RD cycle where complete_data=1; 0 otherwise.
  - The stall counter is frozen while not IDLE.
- Control stall:
  - Trigger: enable_fetch=1 and IMem_dout is BR or JMP. The stall counter loads CTRL_STALL on the next edge.
  - While counter > 0: enable_fetch=0 and enable_updatePC=0. Decode, execute and writeback continue, so the branch drains. The counter decrements each non-memory cycle.
  - In the cycle counter==1:
    - enable_updatePC=1.
    - br_taken=1 if IR_Exec is JMP, or IR_Exec is BR and |(IR_Exec[11:9] & psr).
    - br_taken=0 otherwise, and 0 in all other cycles.
  - The next cycle enable_fetch resumes.
  - enable_decode is 0 for the cycle after the branch leaves decode, until fetch resumes (bubble).
- Simultaneous events:
  - A memory op entering the FSM in the same cycle a BR/JMP is fetched: both are recorded, and memory takes priority.
  - A BR is never fetched while the counter > 0, because fetch is off.
- Bypass (combinational, registered one cycle, valid when enable_decode was 1):
  - bypass_alu_1 = IR_Exec ALU op and IR_Exec[11:9]==IR[8:6] and IR is ALU/LDR/STR/JMP.
  - bypass_alu_2 = IR_Exec ALU op and IR_Exec[11:9]==IR[2:0] and IR is ADD/AND with IR[5]=0.
  - bypass_mem_1 / bypass_mem_2: same conditions, but with IR_Exec a load (LD/LDR/LDI).
  - ALU and mem versions are mutually exclusive by construction.

Test Plan:
- Reset release with no stimulus → enable_fetch at cycle 1, decode at 2, execute at 3, writeback at 4; mem_state=3 throughout.
- IMem_dout=0x0E02 (BRnzp), psr=3'b010, CTRL_STALL=3 → fetch low for 3 cycles; br_taken=1 and enable_updatePC=1 in the third cycle; fetch high on the fourth.
- BRn (0x0802) with psr=3'b001 → identical stall timing, br_taken=0.
- IR_Exec=0xA201 (LDI), complete_data pulsed after 2 cycles, then after 1 cycle → mem_state 1,1,0,3; execute/decode/fetch low for the duration; writeback pulse on the RD-complete cycle.
- IR_Exec=0x1261 (ADD R1,R1,#1), IR=0x1441 (ADD R2,R1,R1) → bypass_alu_1=1, bypass_alu_2=1, mem bypasses 0.
- reset asserted in mem_state=2 (ST waiting) → next cycle mem_state=3, all enables 0; fill sequence restarts after release.

Source files
------------

// File: rtl/lc3_pipe_controller_if.sv
// Handshake bundle between the LC-3 datapath and its pipeline controller.
// The datapath side takes the master modport; the controller takes the slave modport.
interface lc3_pipe_controller_if;
  logic [15:0] IMem_dout;
  logic [15:0] IR;
  logic [15:0] IR_Exec;
  logic [2:0]  psr;
  logic        complete_data;

  logic        enable_fetch;
  logic        enable_updatePC;
  logic        enable_decode;
  logic        enable_execute;
  logic        enable_writeback;
  logic        br_taken;
  logic [1:0]  mem_state;
  logic        bypass_alu_1;
  logic        bypass_alu_2;
  logic        bypass_mem_1;
  logic        bypass_mem_2;

  modport master (
    output IMem_dout, IR, IR_Exec, psr, complete_data,
    input  enable_fetch, enable_updatePC, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );

  modport slave (
    input  IMem_dout, IR, IR_Exec, psr, complete_data,
    output enable_fetch, enable_updatePC, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state,
           bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2
  );
endinterface

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: post-reset fill, BR/JMP fetch stall, multi-cycle
// data-memory FSM and registered ALU/memory bypass selects for execute.
module lc3_pipe_controller #(
  parameter int CTRL_STALL = 3,
  parameter int FILL_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  lc3_pipe_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_IND  = 2'd1,
    MEM_WR   = 2'd2,
    MEM_IDLE = 2'd3
  } mem_state_e;

  localparam logic [3:0] OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
                         OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9,
                         OP_LDI = 4'hA, OP_STI = 4'hB, OP_JMP = 4'hC, OP_LEA = 4'hE;

  localparam logic [1:0] FILL_LAST  = 2'(FILL_DEPTH - 1);
  localparam logic [2:0] STALL_LOAD = 3'(CTRL_STALL);

  function automatic logic is_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_AND, OP_NOT, OP_LEA};
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LD, OP_LDR, OP_LDI};
  endfunction

  logic [3:0] if_op, id_op, ex_op;
  assign if_op = bus.IMem_dout[15:12];
  assign id_op = bus.IR[15:12];
  assign ex_op = bus.IR_Exec[15:12];

  mem_state_e mem_q, mem_d;
  logic [1:0] fill_cnt;
  logic [2:0] stall_cnt;
  logic [3:0] bypass_q, bypass_d;

  logic en_fetch, en_upc, en_decode, en_execute, en_writeback, taken;
  logic in_mem, stalling, last_stall, bubble;
  logic src1_used, src2_used, hit1, hit2;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    mem_d      = mem_q;
    in_mem     = (mem_q != MEM_IDLE);
    stalling   = (stall_cnt != 3'd0);
    last_stall = (stall_cnt == 3'd1);
    // The decode bubble starts once the branch has moved on to execute.
    bubble     = stalling && (stall_cnt != STALL_LOAD);

    en_fetch     = !reset && !in_mem && !stalling;
    en_upc       = !reset && !in_mem && (!stalling || last_stall);
    en_decode    = !reset && !in_mem && (fill_cnt >= 2'd1) && !bubble;
    en_execute   = !reset && !in_mem && (fill_cnt >= 2'd2);
    en_writeback = !reset && (in_mem ? (mem_q == MEM_RD && bus.complete_data)
                                     : (fill_cnt >= 2'd3));
    taken        = !reset && !in_mem && last_stall &&
                   ((ex_op == OP_JMP) ||
                    (ex_op == OP_BR && |(bus.IR_Exec[11:9] & bus.psr)));

    unique case (mem_q)
      MEM_IDLE: begin
        if (en_execute) begin
          if (ex_op inside {OP_LD, OP_LDR})       mem_d = MEM_RD;
          else if (ex_op inside {OP_ST, OP_STR})  mem_d = MEM_WR;
          else if (ex_op inside {OP_LDI, OP_STI}) mem_d = MEM_IND;
        end
      end
      // Execute is frozen here, so IR_Exec still holds the LDI/STI.
      MEM_IND:         if (bus.complete_data) mem_d = (ex_op == OP_LDI) ? MEM_RD : MEM_WR;
      MEM_RD, MEM_WR:  if (bus.complete_data) mem_d = MEM_IDLE;
      default:         mem_d = MEM_IDLE;
    endcase

    src1_used = is_alu(id_op) || (id_op inside {OP_LDR, OP_STR, OP_JMP});
    src2_used = (id_op == OP_ADD || id_op == OP_AND) && !bus.IR[5];
    hit1      = (bus.IR_Exec[11:9] == bus.IR[8:6]);
    hit2      = (bus.IR_Exec[11:9] == bus.IR[2:0]);
    bypass_d  = {is_alu(ex_op)  && hit1 && src1_used,
                 is_alu(ex_op)  && hit2 && src2_used,
                 is_load(ex_op) && hit1 && src1_used,
                 is_load(ex_op) && hit2 && src2_used};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q     <= MEM_IDLE;
      fill_cnt  <= '0;
      stall_cnt <= '0;
      bypass_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values.
      mem_q <= mem_d;
      if (fill_cnt != FILL_LAST) fill_cnt <= fill_cnt + 2'd1;
      if (en_fetch && (if_op == OP_BR || if_op == OP_JMP)) stall_cnt <= STALL_LOAD;
      else if (stalling && !in_mem)                         stall_cnt <= stall_cnt - 3'd1;
      // Selects follow the instruction into execute and hold while it is frozen.
      if (en_decode) bypass_q <= bypass_d;
    end
  end

  assign bus.enable_fetch     = en_fetch;
  assign bus.enable_updatePC  = en_upc;
  assign bus.enable_decode    = en_decode;
  assign bus.enable_execute   = en_execute;
  assign bus.enable_writeback = en_writeback;
  assign bus.br_taken         = taken;
  assign bus.mem_state        = reset ? MEM_IDLE : mem_q;
  assign bus.bypass_alu_1     = !reset && bypass_q[3];
  assign bus.bypass_alu_2     = !reset && bypass_q[2];
  assign bus.bypass_mem_1     = !reset && bypass_q[1];
  assign bus.bypass_mem_2     = !reset && bypass_q[0];

  logic unused_bits;
  assign unused_bits = ^{bus.IMem_dout[11:0], bus.IR[11:9], bus.IR[4:3], bus.IR_Exec[8:0]};

endmodule
